// File: rtl/irq_pending_encoder_if.sv
// rtl/irq_pending_encoder_if.sv - request/mask/flush inputs and index handshake of the pending encoder
interface irq_pending_encoder_if #(
    parameter int N_REQ = 8
) ();
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] mask_i;
    logic             clear_i;
    logic [IDX_W-1:0] idx_o;
    logic             valid_o;
    logic             ready_i;
    logic             none_o;

    modport slave (
        input  req_i,
        input  mask_i,
        input  clear_i,
        input  ready_i,
        output idx_o,
        output valid_o,
        output none_o
    );

    modport master (
        output req_i,
        output mask_i,
        output clear_i,
        output ready_i,
        input  idx_o,
        input  valid_o,
        input  none_o
    );
endinterface

// File: rtl/irq_pending_encoder.sv
// rtl/irq_pending_encoder.sv - pending capture, mask and registered priority slot; IRQ_EDGE_DETECT_EN selects edge capture
module irq_pending_encoder #(
    parameter int N_REQ = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    irq_pending_encoder_if.slave  bus
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] cap;
    logic [N_REQ-1:0] acc_bit;
    logic [N_REQ-1:0] elig;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             acc;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N_REQ-1:0] req_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q <= '0;
        end else begin
            req_q <= bus.req_i;
        end
    end

    assign cap = bus.req_i & ~req_q;
`else
    assign cap = bus.req_i;
`endif

    assign acc     = valid_q && bus.ready_i;
    assign acc_bit = acc ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx_q) : '0;
    // The accepted bit is excluded so the slot reloads with the next winner without a bubble.
    assign elig    = pending & ~bus.mask_i & ~acc_bit;

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (elig[i]) begin
                sel = i[IDX_W-1:0];
            end
        end
    end

    // Capture is OR-ed after the accept clear so a same-cycle set survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else if (bus.clear_i) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~acc_bit) | cap;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.clear_i) begin
            valid_q <= 1'b0;
        end else if (!valid_q || bus.ready_i) begin
            if (elig != '0) begin
                idx_q   <= sel;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.idx_o   = idx_q;
    assign bus.valid_o = valid_q;
    assign bus.none_o  = ~|(pending & ~bus.mask_i);
endmodule

// File: tb/tb_irq_pending_encoder.sv
// tb/tb_irq_pending_encoder.sv - directed vector bench for irq_pending_encoder
module tb_irq_pending_encoder;
    logic clk = 1'b0;
    logic reset_n;

    irq_pending_encoder_if #(.N_REQ(8)) bus ();

    irq_pending_encoder #(.N_REQ(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       clear;
        logic       ready;
        logic       e_valid;
        logic [2:0] e_idx;
        logic       e_none;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic [7:0] req, logic [7:0] mask, logic clear, logic ready,
                                logic e_valid, logic [2:0] e_idx, logic e_none);
        vec_t v;
        v.req = req; v.mask = mask; v.clear = clear; v.ready = ready;
        v.e_valid = e_valid; v.e_idx = e_idx; v.e_none = e_none;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] req, input logic [7:0] mask, input logic clear, input logic ready);
        bus.req_i   = req;
        bus.mask_i  = mask;
        bus.clear_i = clear;
        bus.ready_i = ready;
    endtask

    int grants;
    int exp_grants;
    int wait_cnt;

    initial begin
        // Outputs are checked #1 after the edge that consumed the vector's inputs.
        vecs[0]  = mk(8'h00, 8'h00, 0, 1, 0, 3'd0, 1);
        vecs[1]  = mk(8'h24, 8'h00, 0, 1, 0, 3'd0, 0);
        vecs[2]  = mk(8'h00, 8'h00, 0, 1, 1, 3'd5, 0);
        vecs[3]  = mk(8'h00, 8'h00, 0, 1, 1, 3'd2, 0);
        vecs[4]  = mk(8'h00, 8'h00, 0, 1, 0, 3'd2, 1);
        vecs[5]  = mk(8'h00, 8'h00, 0, 1, 0, 3'd2, 1);
        vecs[6]  = mk(8'h04, 8'h00, 0, 0, 0, 3'd2, 0);
        vecs[7]  = mk(8'h00, 8'h00, 0, 0, 1, 3'd2, 0);
        vecs[8]  = mk(8'h80, 8'h00, 0, 0, 1, 3'd2, 0);
        vecs[9]  = mk(8'h00, 8'h00, 0, 0, 1, 3'd2, 0);
        vecs[10] = mk(8'h00, 8'h00, 0, 1, 1, 3'd7, 0);
        vecs[11] = mk(8'h00, 8'h00, 0, 1, 0, 3'd7, 1);
        vecs[12] = mk(8'h82, 8'h80, 0, 1, 0, 3'd7, 0);
        vecs[13] = mk(8'h00, 8'h80, 0, 1, 1, 3'd1, 0);
        vecs[14] = mk(8'h00, 8'h80, 0, 1, 0, 3'd1, 1);
        vecs[15] = mk(8'h00, 8'h80, 0, 1, 0, 3'd1, 1);
        vecs[16] = mk(8'h00, 8'h00, 0, 0, 1, 3'd7, 0);
        vecs[17] = mk(8'h00, 8'h80, 0, 0, 1, 3'd7, 1);
        vecs[18] = mk(8'h00, 8'h00, 0, 1, 0, 3'd7, 1);
        vecs[19] = mk(8'hFF, 8'h00, 0, 0, 0, 3'd7, 0);
        vecs[20] = mk(8'h00, 8'h00, 0, 0, 1, 3'd7, 0);
        vecs[21] = mk(8'hFF, 8'h00, 1, 1, 0, 3'd7, 1);
        vecs[22] = mk(8'h00, 8'h00, 0, 1, 0, 3'd7, 1);
        vecs[23] = mk(8'h00, 8'h00, 0, 1, 0, 3'd7, 1);

        reset_n = 1'b0;
        drive(8'h00, 8'h00, 0, 1);
        tick();
        chk("rst_valid", {7'd0, bus.valid_o}, 8'd0);
        chk("rst_idx",   {5'd0, bus.idx_o},   8'd0);
        chk("rst_none",  {7'd0, bus.none_o},  8'd1);
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].req, vecs[i].mask, vecs[i].clear, vecs[i].ready);
            tick();
            chk($sformatf("v%0d_valid", i), {7'd0, bus.valid_o}, {7'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_idx", i),   {5'd0, bus.idx_o},   {5'd0, vecs[i].e_idx});
            chk($sformatf("v%0d_none", i),  {7'd0, bus.none_o},  {7'd0, vecs[i].e_none});
        end

        // Level: regrant every other edge while held; edge: a single grant.
`ifdef IRQ_EDGE_DETECT_EN
        exp_grants = 1;
`else
        exp_grants = 5;
`endif
        grants = 0;
        for (int c = 0; c < 16; c++) begin
            drive((c < 10) ? 8'h08 : 8'h00, 8'h00, 0, 1);
            if (bus.valid_o && bus.ready_i) begin
                chk("hold_idx", {5'd0, bus.idx_o}, 8'd3);
                grants++;
            end
            tick();
        end
        chk("hold_grants", grants[7:0], exp_grants[7:0]);
        chk("hold_idle", {7'd0, bus.valid_o}, 8'd0);

        // A masked pending bit is retained across many cycles.
        drive(8'h01, 8'h01, 0, 1);
        tick();
        drive(8'h00, 8'h01, 0, 1);
        for (int c = 0; c < 20; c++) tick();
        chk("masked_valid", {7'd0, bus.valid_o}, 8'd0);
        chk("masked_none",  {7'd0, bus.none_o},  8'd1);
        drive(8'h00, 8'h00, 0, 0);
        #1;
        chk("unmask_none", {7'd0, bus.none_o}, 8'd0);
        wait_cnt = 0;
        while (!bus.valid_o && wait_cnt < 5) begin
            tick();
            wait_cnt++;
        end
        chk("unmask_valid", {7'd0, bus.valid_o}, 8'd1);
        chk("unmask_idx",   {5'd0, bus.idx_o},   8'd0);
        chk("unmask_lat",   wait_cnt[7:0],       8'd1);
        drive(8'h00, 8'h00, 0, 1);
        tick();
        chk("unmask_done", {7'd0, bus.valid_o}, 8'd0);

        // Reset mid-grant clears outputs without waiting for an edge.
        drive(8'h10, 8'h00, 0, 0);
        tick();
        drive(8'h00, 8'h00, 0, 0);
        tick();
        chk("pre_rst_idx", {5'd0, bus.idx_o}, 8'd4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {7'd0, bus.valid_o}, 8'd0);
        chk("mid_rst_idx",   {5'd0, bus.idx_o},   8'd0);
        chk("mid_rst_none",  {7'd0, bus.none_o},  8'd1);
        tick();
        reset_n = 1'b1;
        drive(8'h00, 8'h00, 0, 1);
        tick();
        tick();
        chk("post_rst_valid", {7'd0, bus.valid_o}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
